hazard_unit_ooo_mdu: RTL and testbench
======================================

Name: hazard_unit_ooo_mdu

Overview:
Next-generation pipeline hazard controller for the 5-stage MIPS core (F/D/E/M/W). The multiply/divide unit (MDU) runs in the background; it no longer freezes E. HI/LO are tracked by a small scoreboard FSM, so only instructions that touch HI/LO wait on it. Also adds precise exception flush, a stall watchdog and per-stage stall/flush vectors. Forwarding muxes stay in the datapath; this block owns only stall, flush and HI/LO busy state.

Parameters:
REGW, 5, register-index width
MUL_LAT, 3, fixed multiply latency in cycles from issue in E (>=1)
WDOG_LIMIT, 64, consecutive stallD cycles before hazard_err sets (>=2)
PERF_W, 32, width of optional performance counters

Ports:
clk  in  1  core clock
rst  in  1  synchronous active-high reset
rsD, rtD, rdD  in  REGW  D-stage source/dest indices
branchD, hilotoregD, hiwriteD, lowriteD, mdustartD  in  1  D-stage decode flags
rtE, writeregE  in  REGW  E-stage indices
regwriteE, memtoregE, mdustartE, isdivE  in  1  E-stage flags (mdustartE = mult/div in E)
writeregM  in  REGW  M-stage dest
regwriteM, memtoregM, excM  in  1  M-stage flags; excM = exception/redirect taken in M
divdone  in  1  divider result-valid pulse
stallF, stallD, stallE, stallM, stallW  out  1  hold stage register
flushF, flushD, flushE, flushM, flushW  out  1  clear stage register to bubble
mdu_busy  out  1  HI/LO result pending
mdu_commit  out  1  one-cycle pulse: MDU writes HI/LO this cycle
hazard_err  out  1  sticky watchdog flag

Behaviour:
- Clock and reset: one clock, clk; rst synchronous active-high. On reset: FSM in IDLE, counters 0, hazard_err=0, mdu_busy=0, mdu_commit=0. All stall/flush outputs are 0 in the cycle after reset, given excM=0 and no hazard inputs.
- MDU FSM, states IDLE, MUL, DIV:
  - issue = mdustartE & ~excM & state==IDLE.
  - IDLE -> MUL on issue & ~isdivE; load cnt = MUL_LAT-1.
  - IDLE -> DIV on issue & isdivE.
  - MUL: cnt decrements each cycle; at cnt==0, mdu_commit=1 and next state is IDLE. MUL_LAT=1 therefore commits the cycle after issue.
  - DIV: mdu_commit=divdone; divdone -> IDLE. divdone in IDLE or MUL is ignored.
  - mdu_busy = (state!=IDLE).
  - An issued MDU op is never cancelled by a later excM.
- Hazard terms (combinational):
  - lwstall = memtoregE & rtE!=0 & (rtE==rsD | rtE==rtD).
  - branchstall = branchD & ((regwriteE & writeregE!=0 & (writeregE==rsD | writeregE==rtD)) | (memtoregM & writeregM!=0 & (writeregM==rsD | writeregM==rtD))).
  - mfhistall = hilotoregD & rdD!=0 & ((regwriteE & writeregE==rdD) | (regwriteM & writeregM==rdD)).
  - hilostall = (hilotoregD | hiwriteD | lowriteD | mdustartD) & (mdu_busy | mdustartE).
- Outputs:
  - stallD = ~excM & (lwstall | branchstall | mfhistall | hilostall); stallF = stallD.
  - stallE = stallM = stallW = 0.
  - flushE = stallD | excM; flushD = excM; flushM = excM; flushF = flushW = 0.
  - excM has priority: it suppresses stallD in the same cycle.
- Watchdog: wcnt increments while stallD=1 and clears when stallD=0. When wcnt reaches WDOG_LIMIT-1 while stalling, hazard_err sets and stays set until rst. wcnt saturates.
- Reset mid-operation (MUL or DIV busy): returns to IDLE next edge; no mdu_commit is produced.

Optional Feature:
HAZARD_PERF_EN.
- When defined: adds outputs perf_lw, perf_branch, perf_hilo, each PERF_W wide. Each is a saturating counter of cycles in which that term causes stallD. When several terms are active, all of them count. Counters reset on rst.
- When undefined: these ports and counters do not exist, and behaviour is otherwise identical.

Decomposition:
- Shared package hazard_pkg: mdu_state_t enum {IDLE, MUL, DIV}; stage index constants ST_F..ST_W; REGW default.
- One sub-module, hilo_tracker: contains the MDU FSM and latency counter, with outputs mdu_busy and mdu_commit. Stall/flush logic and the watchdog stay in the top level.

Test Plan:
- Load-use: memtoregE=1, rtE=8, rsD=8 -> stallF=stallD=flushE=1 for exactly 1 cycle; no stall when rtE=0.
- MUL_LAT=3 multiply issue at cycle t -> mdu_busy cycles t+1..t+3, mdu_commit at t+3. mfhi (hilotoregD) in D at t+1 stalls until t+3, released at t+4. Independent ADD in D is not stalled.
- Divide issue, divdone at t+17 -> mdu_busy t+1..t+17, mdu_commit at t+17 only. mtlo in D during busy stalls. A spurious divdone while IDLE has no effect.
- excM=1 while lwstall is active -> stallD=0, flushD=flushE=flushM=1. A simultaneous mdustartE does not issue (mdu_busy stays 0).
- branchD with rsD=writeregE=5, regwriteE=1 held 64 cycles (WDOG_LIMIT=64) -> hazard_err=1 on the 64th stall cycle and sticky; rst clears it.
- rst asserted during MUL state -> next cycle mdu_busy=0, no mdu_commit, all stall/flush outputs 0.

Source files
------------

// File: rtl/hazard_unit_ooo_mdu_pkg.sv
// hazard_pkg: shared types and constants for the hazard controller slice.
//   mdu_state_t : HI/LO scoreboard FSM states
//   ST_F..ST_W  : bit positions of each pipeline stage in stall/flush vectors
//   REGW_DEF    : default register-index width
package hazard_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2
  } mdu_state_t;

  localparam int unsigned ST_F = 0;
  localparam int unsigned ST_D = 1;
  localparam int unsigned ST_E = 2;
  localparam int unsigned ST_M = 3;
  localparam int unsigned ST_W = 4;

  localparam int unsigned REGW_DEF = 5;

endpackage

// File: rtl/hazard_unit_ooo_mdu_hilo_tracker.sv
// hilo_tracker: background MDU scoreboard. Tracks whether a HI/LO result is
// still pending and pulses mdu_commit in the cycle the MDU writes HI/LO.
//   clk, rst     : clock, synchronous active-high reset
//   mdustartE    : mult/div instruction in E
//   isdivE       : the E-stage MDU op is a divide
//   excM         : exception in M; blocks a new issue in the same cycle
//   divdone      : divider result-valid pulse (only honoured in DIV)
//   mdu_busy     : HI/LO result pending
//   mdu_commit   : one-cycle HI/LO write pulse
module hilo_tracker
  import hazard_pkg::*;
#(
  parameter int unsigned MUL_LAT = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic mdustartE,
  input  logic isdivE,
  input  logic excM,
  input  logic divdone,
  output logic mdu_busy,
  output logic mdu_commit
);

  localparam int unsigned CW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

  mdu_state_t    state, stateNext;
  logic [CW-1:0] cnt, cntNext;
  logic          issue;

  assign issue = mdustartE & ~excM & (state == IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= stateNext;
      cnt   <= cntNext;
    end
  end

  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    case (state)
      IDLE: begin
        if (issue) begin
          if (isdivE) begin
            stateNext = DIV;
          end else begin
            stateNext = MUL;
            cntNext   = CW'(MUL_LAT - 1);
          end
        end
      end
      MUL: begin
        if (cnt == '0) stateNext = IDLE;
        else           cntNext   = cnt - CW'(1);
      end
      DIV: begin
        if (divdone) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  // Commit is masked during reset so a busy op aborted by rst never writes HI/LO.
  always_comb begin
    mdu_busy   = (state != IDLE);
    mdu_commit = 1'b0;
    if (!rst) begin
      case (state)
        MUL:     mdu_commit = (cnt == '0);
        DIV:     mdu_commit = divdone;
        default: mdu_commit = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/hazard_unit_ooo_mdu.sv
// hazard_unit_ooo_mdu: stall/flush controller for the 5-stage MIPS pipeline
// with a background MDU. Only HI/LO users wait on the MDU; exceptions in M
// flush D/E/M and override any D stall; a sticky watchdog flags long stalls.
//   D inputs : rsD, rtD, rdD, branchD, hilotoregD, hiwriteD, lowriteD, mdustartD
//   E inputs : rtE, writeregE, regwriteE, memtoregE, mdustartE, isdivE
//   M inputs : writeregM, regwriteM, memtoregM, excM; divdone from divider
//   Outputs  : stallF..stallW, flushF..flushW, mdu_busy, mdu_commit, hazard_err
// Optional build macro HAZARD_PERF_EN adds saturating stall-cause counters
// perf_lw, perf_branch, perf_hilo (PERF_W bits each).
module hazard_unit_ooo_mdu
  import hazard_pkg::*;
#(
  parameter int unsigned REGW       = REGW_DEF,
  parameter int unsigned MUL_LAT    = 3,
  parameter int unsigned WDOG_LIMIT = 64,
  parameter int unsigned PERF_W     = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [REGW-1:0] rsD,
  input  logic [REGW-1:0] rtD,
  input  logic [REGW-1:0] rdD,
  input  logic            branchD,
  input  logic            hilotoregD,
  input  logic            hiwriteD,
  input  logic            lowriteD,
  input  logic            mdustartD,
  input  logic [REGW-1:0] rtE,
  input  logic [REGW-1:0] writeregE,
  input  logic            regwriteE,
  input  logic            memtoregE,
  input  logic            mdustartE,
  input  logic            isdivE,
  input  logic [REGW-1:0] writeregM,
  input  logic            regwriteM,
  input  logic            memtoregM,
  input  logic            excM,
  input  logic            divdone,
  output logic            stallF,
  output logic            stallD,
  output logic            stallE,
  output logic            stallM,
  output logic            stallW,
  output logic            flushF,
  output logic            flushD,
  output logic            flushE,
  output logic            flushM,
  output logic            flushW,
  output logic            mdu_busy,
  output logic            mdu_commit,
`ifdef HAZARD_PERF_EN
  output logic [PERF_W-1:0] perf_lw,
  output logic [PERF_W-1:0] perf_branch,
  output logic [PERF_W-1:0] perf_hilo,
`endif
  output logic            hazard_err
);

  localparam int unsigned WW = $clog2(WDOG_LIMIT);
  localparam logic [WW-1:0] WDOG_LAST = WW'(WDOG_LIMIT - 1);

  logic lwstall, branchstall, mfhistall, hilostall, stallAny;
  logic [4:0] stallV, flushV;
  logic [WW-1:0] wcnt;
  logic errReg, wdogHit;

  hilo_tracker #(.MUL_LAT(MUL_LAT)) uTracker (
    .clk        (clk),
    .rst        (rst),
    .mdustartE  (mdustartE),
    .isdivE     (isdivE),
    .excM       (excM),
    .divdone    (divdone),
    .mdu_busy   (mdu_busy),
    .mdu_commit (mdu_commit)
  );

  always_comb begin
    lwstall     = memtoregE & (rtE != '0) & ((rtE == rsD) | (rtE == rtD));
    branchstall = branchD &
                  ((regwriteE & (writeregE != '0) & ((writeregE == rsD) | (writeregE == rtD))) |
                   (memtoregM & (writeregM != '0) & ((writeregM == rsD) | (writeregM == rtD))));
    mfhistall   = hilotoregD & (rdD != '0) &
                  ((regwriteE & (writeregE == rdD)) | (regwriteM & (writeregM == rdD)));
    hilostall   = (hilotoregD | hiwriteD | lowriteD | mdustartD) & (mdu_busy | mdustartE);
    stallAny    = ~excM & (lwstall | branchstall | mfhistall | hilostall);
  end

  always_comb begin
    stallV       = '0;
    flushV       = '0;
    stallV[ST_D] = stallAny;
    stallV[ST_F] = stallAny;
    flushV[ST_D] = excM;
    flushV[ST_E] = stallAny | excM;
    flushV[ST_M] = excM;
  end

  assign stallF = stallV[ST_F];
  assign stallD = stallV[ST_D];
  assign stallE = stallV[ST_E];
  assign stallM = stallV[ST_M];
  assign stallW = stallV[ST_W];
  assign flushF = flushV[ST_F];
  assign flushD = flushV[ST_D];
  assign flushE = flushV[ST_E];
  assign flushM = flushV[ST_M];
  assign flushW = flushV[ST_W];

  // The limit-th consecutive stall cycle raises hazard_err immediately;
  // errReg keeps it asserted afterwards.
  assign wdogHit    = stallD & (wcnt == WDOG_LAST);
  assign hazard_err = errReg | wdogHit;

  always_ff @(posedge clk) begin
    if (rst) begin
      wcnt   <= '0;
      errReg <= 1'b0;
    end else if (stallD) begin
      if (wcnt != WDOG_LAST) wcnt <= wcnt + WW'(1);
      if (wdogHit) errReg <= 1'b1;
    end else begin
      wcnt <= '0;
    end
  end

`ifdef HAZARD_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_lw     <= '0;
      perf_branch <= '0;
      perf_hilo   <= '0;
    end else begin
      if (~excM & lwstall & (perf_lw != '1))         perf_lw     <= perf_lw + PERF_W'(1);
      if (~excM & branchstall & (perf_branch != '1)) perf_branch <= perf_branch + PERF_W'(1);
      if (~excM & hilostall & (perf_hilo != '1))     perf_hilo   <= perf_hilo + PERF_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_hazard_unit_ooo_mdu.sv
module tb_hazard_unit_ooo_mdu;

  localparam int unsigned MUL_LAT    = 3;
  localparam int unsigned WDOG_LIMIT = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       rst;
    logic [4:0] rsD, rtD, rdD;
    logic       branchD, hilotoregD, hiwriteD, lowriteD, mdustartD;
    logic [4:0] rtE, writeregE;
    logic       regwriteE, memtoregE, mdustartE, isdivE;
    logic [4:0] writeregM;
    logic       regwriteM, memtoregM, excM, divdone;
  } in_t;

  typedef struct {
    in_t         i;
    logic [12:0] e;
    bit          chk;
    string       name;
  } row_t;

  typedef struct {
    logic [12:0] e;
    bit          chk;
    string       name;
  } sb_t;

  logic       rst;
  logic [4:0] rsD, rtD, rdD, rtE, writeregE, writeregM;
  logic       branchD, hilotoregD, hiwriteD, lowriteD, mdustartD;
  logic       regwriteE, memtoregE, mdustartE, isdivE;
  logic       regwriteM, memtoregM, excM, divdone;
  logic       stallF, stallD, stallE, stallM, stallW;
  logic       flushF, flushD, flushE, flushM, flushW;
  logic       mdu_busy, mdu_commit, hazard_err;
`ifdef HAZARD_PERF_EN
  logic [31:0] perf_lw, perf_branch, perf_hilo;
`endif

  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  sb_t sbq[$];

  hazard_unit_ooo_mdu #(
    .REGW(5), .MUL_LAT(MUL_LAT), .WDOG_LIMIT(WDOG_LIMIT), .PERF_W(32)
  ) dut (
    .clk(clk), .rst(rst),
    .rsD(rsD), .rtD(rtD), .rdD(rdD),
    .branchD(branchD), .hilotoregD(hilotoregD), .hiwriteD(hiwriteD),
    .lowriteD(lowriteD), .mdustartD(mdustartD),
    .rtE(rtE), .writeregE(writeregE), .regwriteE(regwriteE),
    .memtoregE(memtoregE), .mdustartE(mdustartE), .isdivE(isdivE),
    .writeregM(writeregM), .regwriteM(regwriteM), .memtoregM(memtoregM),
    .excM(excM), .divdone(divdone),
    .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM), .stallW(stallW),
    .flushF(flushF), .flushD(flushD), .flushE(flushE), .flushM(flushM), .flushW(flushW),
    .mdu_busy(mdu_busy), .mdu_commit(mdu_commit),
`ifdef HAZARD_PERF_EN
    .perf_lw(perf_lw), .perf_branch(perf_branch), .perf_hilo(perf_hilo),
`endif
    .hazard_err(hazard_err)
  );

  logic [12:0] obs;
  assign obs = {stallF, stallD, stallE, stallM, stallW,
                flushF, flushD, flushE, flushM, flushW,
                mdu_busy, mdu_commit, hazard_err};

  // Expected output vector: stallF follows stallD, flushE = stall | exc,
  // flushD = flushM = exc, E/M/W never stall, F/W never flush.
  function automatic logic [12:0] ev(bit st, bit ex, bit busy, bit com, bit err);
    return {st, st, 1'b0, 1'b0, 1'b0,
            1'b0, ex, st | ex, ex, 1'b0,
            busy, com, err};
  endfunction

  function automatic row_t mk(string n, in_t i, logic [12:0] e, bit chk = 1'b1);
    row_t r;
    r.i = i; r.e = e; r.chk = chk; r.name = n;
    return r;
  endfunction

  task automatic drive_row(input row_t r);
    sb_t s;
    rst = r.i.rst; rsD = r.i.rsD; rtD = r.i.rtD; rdD = r.i.rdD;
    branchD = r.i.branchD; hilotoregD = r.i.hilotoregD; hiwriteD = r.i.hiwriteD;
    lowriteD = r.i.lowriteD; mdustartD = r.i.mdustartD;
    rtE = r.i.rtE; writeregE = r.i.writeregE; regwriteE = r.i.regwriteE;
    memtoregE = r.i.memtoregE; mdustartE = r.i.mdustartE; isdivE = r.i.isdivE;
    writeregM = r.i.writeregM; regwriteM = r.i.regwriteM; memtoregM = r.i.memtoregM;
    excM = r.i.excM; divdone = r.i.divdone;
    s.e = r.e; s.chk = r.chk; s.name = r.name;
    sbq.push_back(s);
  endtask

  task automatic test_reset();
    row_t rows[$];
    in_t i;
    sb_t s;
    i = '0; i.rst = 1'b1;
    rows.push_back(mk("rst_hold0", i, '0, 1'b0));
    rows.push_back(mk("rst_hold1", i, '0, 1'b0));
    i = '0;
    rows.push_back(mk("reset_state", i, ev(0, 0, 0, 0, 0)));
    foreach (rows[k]) begin
      drive_row(rows[k]);
      @(negedge clk);
      s = sbq.pop_front();
      if (s.chk) begin
        vectors++;
        if (obs !== s.e) begin
          $display("FAIL %s: got %b want %b", s.name, obs, s.e);
          miscompares++;
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_load_use();
    row_t rows[$];
    in_t i;
    sb_t s;
    i = '0; i.memtoregE = 1; i.rtE = 8; i.rsD = 8;
    rows.push_back(mk("lw_rs", i, ev(1, 0, 0, 0, 0)));
    i = '0;
    rows.push_back(mk("lw_release", i, ev(0, 0, 0, 0, 0)));
    i = '0; i.memtoregE = 1;
    rows.push_back(mk("lw_r0", i, ev(0, 0, 0, 0, 0)));
    i = '0; i.memtoregE = 1; i.rtE = 9; i.rtD = 9; i.rsD = 1;
    rows.push_back(mk("lw_rt", i, ev(1, 0, 0, 0, 0)));
    i.memtoregE = 0;
    rows.push_back(mk("lw_noload", i, ev(0, 0, 0, 0, 0)));
    foreach (rows[k]) begin
      drive_row(rows[k]);
      @(negedge clk);
      s = sbq.pop_front();
      if (s.chk) begin
        vectors++;
        if (obs !== s.e) begin
          $display("FAIL %s: got %b want %b", s.name, obs, s.e);
          miscompares++;
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_branch_mfhi();
    row_t rows[$];
    in_t i;
    sb_t s;
    i = '0; i.branchD = 1; i.rsD = 5; i.writeregE = 5; i.regwriteE = 1;
    rows.push_back(mk("br_E", i, ev(1, 0, 0, 0, 0)));
    i.regwriteE = 0;
    rows.push_back(mk("br_E_nowrite", i, ev(0, 0, 0, 0, 0)));
    i = '0; i.branchD = 1; i.regwriteE = 1;
    rows.push_back(mk("br_r0", i, ev(0, 0, 0, 0, 0)));
    i = '0; i.branchD = 1; i.rtD = 7; i.memtoregM = 1; i.writeregM = 7;
    rows.push_back(mk("br_M_load", i, ev(1, 0, 0, 0, 0)));
    i.branchD = 0;
    rows.push_back(mk("nobr_M_load", i, ev(0, 0, 0, 0, 0)));
    i = '0; i.hilotoregD = 1; i.rdD = 4; i.regwriteM = 1; i.writeregM = 4;
    rows.push_back(mk("mfhi_M", i, ev(1, 0, 0, 0, 0)));
    i = '0; i.hilotoregD = 1; i.regwriteE = 1;
    rows.push_back(mk("mfhi_r0", i, ev(0, 0, 0, 0, 0)));
    i = '0; i.hilotoregD = 1; i.rdD = 4; i.regwriteE = 1; i.writeregE = 4;
    rows.push_back(mk("mfhi_E", i, ev(1, 0, 0, 0, 0)));
    i = '0;
    rows.push_back(mk("br_idle", i, ev(0, 0, 0, 0, 0)));
    foreach (rows[k]) begin
      drive_row(rows[k]);
      @(negedge clk);
      s = sbq.pop_front();
      if (s.chk) begin
        vectors++;
        if (obs !== s.e) begin
          $display("FAIL %s: got %b want %b", s.name, obs, s.e);
          miscompares++;
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_mul();
    row_t rows[$];
    in_t i;
    sb_t s;
    // Issue with a dependent MDU op already in D: stalls on mdustartE alone.
    i = '0; i.mdustartE = 1; i.mdustartD = 1;
    rows.push_back(mk("mul_issue", i, ev(1, 0, 0, 0, 0)));
    i = '0; i.hilotoregD = 1; i.rdD = 3;
    for (int k = 1; k <= int'(MUL_LAT); k++)
      rows.push_back(mk($sformatf("mul_mfhi_t%0d", k), i, ev(1, 0, 1, k == int'(MUL_LAT), 0)));
    rows.push_back(mk("mul_mfhi_release", i, ev(0, 0, 0, 0, 0)));
    // Second multiply: independent ADD proceeds; divdone is ignored in MUL.
    i = '0; i.mdustartE = 1;
    rows.push_back(mk("mul2_issue", i, ev(0, 0, 0, 0, 0)));
    i = '0; i.rsD = 1; i.rtD = 2; i.divdone = 1;
    rows.push_back(mk("mul2_add_divdone", i, ev(0, 0, 1, 0, 0)));
    i.divdone = 0;
    rows.push_back(mk("mul2_add", i, ev(0, 0, 1, 0, 0)));
    i = '0; i.hiwriteD = 1;
    rows.push_back(mk("mul2_mthi_commit", i, ev(1, 0, 1, 1, 0)));
    i = '0;
    rows.push_back(mk("mul2_done", i, ev(0, 0, 0, 0, 0)));
    foreach (rows[k]) begin
      drive_row(rows[k]);
      @(negedge clk);
      s = sbq.pop_front();
      if (s.chk) begin
        vectors++;
        if (obs !== s.e) begin
          $display("FAIL %s: got %b want %b", s.name, obs, s.e);
          miscompares++;
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_div();
    row_t rows[$];
    in_t i;
    sb_t s;
    i = '0; i.mdustartE = 1; i.isdivE = 1;
    rows.push_back(mk("div_issue", i, ev(0, 0, 0, 0, 0)));
    for (int k = 1; k <= 16; k++) begin
      i = '0;
      if (k == 5) i.lowriteD = 1;
      rows.push_back(mk($sformatf("div_busy_t%0d", k), i, ev(k == 5, 0, 1, 0, 0)));
    end
    i = '0; i.divdone = 1;
    rows.push_back(mk("div_commit", i, ev(0, 0, 1, 1, 0)));
    i = '0;
    rows.push_back(mk("div_idle", i, ev(0, 0, 0, 0, 0)));
    i.divdone = 1;
    rows.push_back(mk("div_spurious", i, ev(0, 0, 0, 0, 0)));
    i = '0;
    rows.push_back(mk("div_spurious_after", i, ev(0, 0, 0, 0, 0)));
    foreach (rows[k]) begin
      drive_row(rows[k]);
      @(negedge clk);
      s = sbq.pop_front();
      if (s.chk) begin
        vectors++;
        if (obs !== s.e) begin
          $display("FAIL %s: got %b want %b", s.name, obs, s.e);
          miscompares++;
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_exception();
    row_t rows[$];
    in_t i;
    sb_t s;
    i = '0; i.memtoregE = 1; i.rtE = 8; i.rsD = 8; i.excM = 1; i.mdustartE = 1;
    rows.push_back(mk("exc_over_lw", i, ev(0, 1, 0, 0, 0)));
    i = '0;
    rows.push_back(mk("exc_no_issue", i, ev(0, 0, 0, 0, 0)));
    // A multiply already issued survives a later exception.
    i = '0; i.mdustartE = 1;
    rows.push_back(mk("exc_mul_issue", i, ev(0, 0, 0, 0, 0)));
    i = '0; i.excM = 1;
    rows.push_back(mk("exc_during_mul", i, ev(0, 1, 1, 0, 0)));
    i = '0;
    for (int k = 2; k <= int'(MUL_LAT); k++)
      rows.push_back(mk($sformatf("exc_mul_t%0d", k), i, ev(0, 0, 1, k == int'(MUL_LAT), 0)));
    rows.push_back(mk("exc_mul_done", i, ev(0, 0, 0, 0, 0)));
    foreach (rows[k]) begin
      drive_row(rows[k]);
      @(negedge clk);
      s = sbq.pop_front();
      if (s.chk) begin
        vectors++;
        if (obs !== s.e) begin
          $display("FAIL %s: got %b want %b", s.name, obs, s.e);
          miscompares++;
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid();
    row_t rows[$];
    in_t i;
    sb_t s;
    i = '0; i.mdustartE = 1;
    rows.push_back(mk("rmid_issue", i, ev(0, 0, 0, 0, 0)));
    i = '0;
    rows.push_back(mk("rmid_busy", i, ev(0, 0, 1, 0, 0)));
    i.rst = 1;
    rows.push_back(mk("rmid_rst", i, '0, 1'b0));
    i = '0;
    for (int k = 0; k < 3; k++)
      rows.push_back(mk($sformatf("rmid_after%0d", k), i, ev(0, 0, 0, 0, 0)));
    foreach (rows[k]) begin
      drive_row(rows[k]);
      @(negedge clk);
      s = sbq.pop_front();
      if (s.chk) begin
        vectors++;
        if (obs !== s.e) begin
          $display("FAIL %s: got %b want %b", s.name, obs, s.e);
          miscompares++;
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_watchdog();
    row_t rows[$];
    in_t i;
    sb_t s;
    i = '0; i.branchD = 1; i.rsD = 5; i.writeregE = 5; i.regwriteE = 1;
    for (int k = 1; k <= int'(WDOG_LIMIT); k++)
      rows.push_back(mk($sformatf("wdog_stall%0d", k), i, ev(1, 0, 0, 0, k == int'(WDOG_LIMIT)),
                        (k <= 2) || (k >= int'(WDOG_LIMIT) - 2)));
    i = '0;
    for (int k = 0; k < 3; k++)
      rows.push_back(mk($sformatf("wdog_sticky%0d", k), i, ev(0, 0, 0, 0, 1)));
    i.rst = 1;
    rows.push_back(mk("wdog_rst", i, '0, 1'b0));
    i = '0;
    rows.push_back(mk("wdog_cleared", i, ev(0, 0, 0, 0, 0)));
    foreach (rows[k]) begin
      drive_row(rows[k]);
      @(negedge clk);
      s = sbq.pop_front();
      if (s.chk) begin
        vectors++;
        if (obs !== s.e) begin
          $display("FAIL %s: got %b want %b", s.name, obs, s.e);
          miscompares++;
        end
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    {rsD, rtD, rdD, rtE, writeregE, writeregM} = '0;
    {branchD, hilotoregD, hiwriteD, lowriteD, mdustartD} = '0;
    {regwriteE, memtoregE, mdustartE, isdivE} = '0;
    {regwriteM, memtoregM, excM, divdone} = '0;
    @(posedge clk); #1;
    test_reset();
    test_load_use();
    test_branch_mfhi();
    test_mul();
    test_div();
    test_exception();
    test_reset_mid();
    test_watchdog();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
